// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - pops bytes from a registered-read FIFO and sends them as UART frames
// Optional even parity bit after the MSB when FIFO_UART_TX_PARITY_EN is defined.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_W       = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_W + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_LOAD,
    S_START,
    S_DATA,
`ifdef FIFO_UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                tx_q, tx_d;
  logic                rd_en_q, rd_en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                bit_end;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                parity_q, parity_d;
`endif

  always_comb begin
    state_d  = state_q;
    baud_d   = bit_end_ok(baud_q) ? '0 : baud_q + 1'b1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    rd_en_d  = 1'b0;
    done_d   = 1'b0;
    bit_end  = (baud_q == BAUD_LAST);
`ifdef FIFO_UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          state_d = S_POP;
          rd_en_d = 1'b1;
        end
      end
      S_POP: begin
        baud_d  = '0;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        baud_d   = '0;
        bit_d    = '0;
        shift_d  = fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d = ^fifo_data;
`endif
        state_d  = S_START;
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
`ifdef FIFO_UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        // bit_q counts stop bits here; the FIFO is only re-examined on the final stop cycle
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            done_d = 1'b1;
            if (!fifo_empty) begin
              state_d = S_POP;
              rd_en_d = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with the state register
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
      S_PARITY: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  function automatic logic bit_end_ok(input logic [BAUD_W-1:0] b);
    return b == BAUD_LAST;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      rd_en_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      rd_en_q  <= rd_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - scoreboard bench: FIFO model feeds the DUT, a UART receiver model decodes tx
module tb_fifo_uart_tx;
  localparam int CPB = 4;
  localparam int DW  = 8;
  localparam int SB  = 2;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NB = 1 + DW + P + SB;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_rd_en, tx, busy, frame_done;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(DW), .STOP_BITS(SB)) dut (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(fifo_rd_en), .tx(tx), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_pass = 0;
  int            pops = 0;
  int            frames = 0;
  int            pushed = 0;
  bit            pop_pending = 0;
  bit            mon_en = 0;
  bit            in_frame = 0;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] pend_q[$];
  logic [DW-1:0] exp_q[$];

  task automatic check(input bit ok, input string name, input int act, input int req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  task automatic push_byte(input logic [DW-1:0] b, input bit expect_it);
    pend_q.push_back(b);
    pushed++;
    if (expect_it) exp_q.push_back(b);
  endtask

  // Registered-read FIFO: data appears the cycle after rd_en is sampled; driven on negedges
  initial forever begin
    @(negedge clk);
    if (reset) begin
      pop_pending = 0;
    end else begin
      if (pop_pending) begin
        fifo_data = fifo_q.pop_front();
        pop_pending = 0;
      end else begin
        fifo_data = DW'($urandom);
      end
      if (fifo_rd_en) begin
        check(fifo_q.size() > 0, "rd_en_while_empty", fifo_q.size(), 1);
        pops++;
        pop_pending = 1;
      end
    end
    while (pend_q.size() > 0) fifo_q.push_back(pend_q.pop_front());
    fifo_empty = (fifo_q.size() == 0);
  end

  task automatic rx_frame(output bit nxt);
    logic          bits[NB];
    logic          first;
    bit            stable = 1, bsy = 1, quiet = 1, more = 0, stops = 1;
    logic [DW-1:0] b, e;
    in_frame = 1;
    first = 1'b0;
    for (int i = 0; i < NB; i++) begin
      for (int c = 0; c < CPB; c++) begin
        if (i != 0 || c != 0) begin @(negedge clk); #2; end
        if (c == 0) first = tx;
        else if (tx !== first) stable = 0;
        if (busy !== 1'b1) bsy = 0;
        if (frame_done !== 1'b0) quiet = 0;
        if (c == CPB / 2) bits[i] = tx;
        if (i == NB - 1 && c == CPB - 1) more = !fifo_empty;
      end
    end
    for (int k = 0; k < DW; k++) b[k] = bits[1 + k];
    for (int s = 0; s < SB; s++) if (bits[1 + DW + P + s] !== 1'b1) stops = 0;
    check(bits[0] === 1'b0, "start_bit", int'(bits[0]), 0);
    check(stops, "stop_bits", int'(stops), 1);
    check(stable, "bit_width_cpb", int'(stable), 1);
    check(bsy, "busy_in_frame", int'(bsy), 1);
    check(quiet, "no_done_mid_frame", int'(quiet), 1);
    check(exp_q.size() > 0, "frame_expected", exp_q.size(), 1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : ~b;
    check(b === e, "rx_byte", int'(b), int'(e));
`ifdef FIFO_UART_TX_PARITY_EN
    check(bits[1 + DW] === ^e, "parity_bit", int'(bits[1 + DW]), int'(^e));
`endif
    @(negedge clk); #2;
    check(frame_done === 1'b1, "frame_done_pulse", int'(frame_done), 1);
    frames++;
    if (more) begin
      check(busy === 1'b1 && tx === 1'b1, "gap_pop_cycle", int'({busy, tx}), 3);
      @(negedge clk); #2;
      check(busy === 1'b1 && tx === 1'b1 && frame_done === 1'b0, "gap_load_cycle",
            int'({busy, tx, frame_done}), 6);
      @(negedge clk); #2;
      check(tx === 1'b0 && busy === 1'b1, "gap_len_2", int'(tx), 0);
      nxt = (tx === 1'b0);
    end else begin
      check(busy === 1'b0 && tx === 1'b1, "idle_after_frame", int'({busy, tx}), 1);
      nxt = 0;
    end
    in_frame = nxt;
  endtask

  initial begin
    bit nxt;
    forever begin
      @(negedge clk); #2;
      if (mon_en) begin
        if (tx === 1'b0) begin
          nxt = 1;
          while (nxt) rx_frame(nxt);
        end else begin
          check(frame_done === 1'b0, "idle_no_done", int'(frame_done), 0);
        end
      end
    end
  end

  task automatic wait_idle(input string name);
    int n = 0;
    while (n < 4000 && (exp_q.size() > 0 || pend_q.size() > 0 || fifo_q.size() > 0 || busy || in_frame)) begin
      @(negedge clk); #3;
      n++;
    end
    check(n < 4000, name, n, 4000);
    repeat (3) @(negedge clk);
    #3;
  endtask

  initial begin
    int n, p0, f0;
    bit ok_tx, ok_rd, ok_done;

    repeat (3) @(negedge clk);
    #3;
    check(tx === 1'b1, "reset_tx", int'(tx), 1);
    check(busy === 1'b0, "reset_busy", int'(busy), 0);
    check(fifo_rd_en === 1'b0, "reset_rd_en", int'(fifo_rd_en), 0);
    check(frame_done === 1'b0, "reset_frame_done", int'(frame_done), 0);
    reset = 1'b0;

    // Reset in the middle of the data bits
    p0 = pops;
    @(negedge clk); #1;
    push_byte(8'h5A, 0);
    n = 0;
    while (pops == p0 && n < 20) begin @(negedge clk); #3; n++; end
    check(n < 20, "t1_pop_seen", n, 20);
    repeat (10) @(negedge clk);
    #3;
    check(busy === 1'b1 && tx === ^tx, "t1_busy_before_reset", int'(busy), 1);
    reset = 1'b1;
    #1;
    check(tx === 1'b1, "t1_tx_async", int'(tx), 1);
    check(busy === 1'b0, "t1_busy_async", int'(busy), 0);
    check(fifo_rd_en === 1'b0, "t1_rd_en_async", int'(fifo_rd_en), 0);
    repeat (2) @(negedge clk);
    #3;
    reset = 1'b0;
    ok_tx = 1; ok_done = 1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); #3;
      if (tx !== 1'b1 || busy !== 1'b0) ok_tx = 0;
      if (frame_done !== 1'b0) ok_done = 0;
    end
    check(ok_tx, "t1_line_idle_after_abort", int'(ok_tx), 1);
    check(ok_done, "t1_no_frame_done", int'(ok_done), 1);
    check(pops == p0 + 1, "t1_single_pop", pops - p0, 1);
    mon_en = 1;

    // Single byte with start-bit latency
    p0 = pops; f0 = frames;
    @(negedge clk); #1;
    push_byte(8'hA5, 1);
    n = 0;
    do begin @(negedge clk); #3; n++; end while (fifo_empty && n < 10);
    n = 0;
    while (tx === 1'b1 && n < 10) begin @(negedge clk); #3; n++; end
    check(n == 3, "t2_start_latency", n, 3);
    wait_idle("t2_timeout");
    check(pops - p0 == 1, "t2_pops", pops - p0, 1);
    check(frames - f0 == 1, "t2_frames", frames - f0, 1);

    // Back-to-back frames
    p0 = pops; f0 = frames;
    push_byte(8'h00, 1);
    push_byte(8'hFF, 1);
    push_byte(8'h3C, 1);
    wait_idle("t3_timeout");
    check(pops - p0 == 3, "t3_pops", pops - p0, 3);
    check(frames - f0 == 3, "t3_frames", frames - f0, 3);
    check(fifo_empty === 1'b1, "t3_fifo_drained", int'(fifo_empty), 1);

    // Empty FIFO
    ok_tx = 1; ok_rd = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #3;
      if (tx !== 1'b1) ok_tx = 0;
      if (fifo_rd_en !== 1'b0) ok_rd = 0;
    end
    check(ok_tx, "t4_tx_idle", int'(ok_tx), 1);
    check(ok_rd, "t4_no_rd_en", int'(ok_rd), 1);

    // Parity-sensitive bytes
    push_byte(8'h07, 1);
    push_byte(8'h03, 1);
    wait_idle("t5_timeout");

    // Random writes: bursty, then sparse so some frames start from idle
    p0 = pops; f0 = frames;
    n = 0;
    while (n < 20) begin
      @(negedge clk); #1;
      if ($urandom_range(0, 2) == 0) begin push_byte(DW'($urandom), 1); n++; end
    end
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 80)) @(negedge clk);
      #1;
      push_byte(DW'($urandom), 1);
    end
    wait_idle("t6_timeout");
    check(pops - p0 == 28, "t6_pops", pops - p0, 28);
    check(frames - f0 == 28, "t6_frames", frames - f0, 28);
    check(pops == pushed, "total_pops", pops, pushed);
    check(frames == pushed - 1, "total_frames", frames, pushed - 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got %0d, required %0d", n_checks, 0);
    $fatal(1, "timeout");
  end
endmodule
